// File: rtl/pattern_cmd_pkg.sv
// Shared constants for pattern_cmd_decoder: opcodes, FSM encodings, serial_out modes.
package pattern_cmd_pkg;

    localparam logic [7:0] OP_WR_DATA = 8'h01;
    localparam logic [7:0] OP_WR_FREQ = 8'h02;
    localparam logic [7:0] OP_START_1 = 8'h03;
    localparam logic [7:0] OP_START_R = 8'h04;
    localparam logic [7:0] OP_STOP    = 8'h05;

    localparam logic MODE_ONE_SHOT = 1'b0;
    localparam logic MODE_REPEAT   = 1'b1;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_PAYLOAD = 2'd1,
        S_CHECK   = 2'd2,
        S_EXEC    = 2'd3
    } state_t;

    function automatic logic op_has_payload(input logic [7:0] op);
        return (op == OP_WR_DATA) || (op == OP_WR_FREQ);
    endfunction

    function automatic logic op_is_ctrl(input logic [7:0] op);
        return (op == OP_START_1) || (op == OP_START_R) || (op == OP_STOP);
    endfunction

endpackage

// File: rtl/cmd_timeout_cnt.sv
// Clearable up-counter; o_tick fires in the cycle the count sits at TERM-1 while enabled.
module cmd_timeout_cnt #(
    parameter int TERM = 100000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_clr,
    input  logic i_en,
    output logic o_tick
);
    localparam int CW = ($clog2(TERM) > 0) ? $clog2(TERM) : 1;

    logic [CW-1:0] r_cnt;
    logic          w_term;

    assign w_term = (r_cnt == CW'(TERM - 1));
    assign o_tick = i_en && !i_clr && w_term;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_cnt <= '0;
        else if (i_clr)
            r_cnt <= '0;
        else if (i_en)
            r_cnt <= w_term ? '0 : r_cnt + CW'(1);
    end

endmodule

// File: rtl/pattern_cmd_decoder.sv
// UART byte stream -> command frames for serial_out; staged pattern writes with deferred commit.
// Optional trailing XOR checksum byte per frame when CMD_CHECKSUM_EN is defined.
module pattern_cmd_decoder
    import pattern_cmd_pkg::*;
#(
    parameter int DATA_BIT       = 32,
    parameter int TIMEOUT_CYCLES = 100000
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [7:0]          i_rx_data,
    input  logic                i_rx_done_tick,
    input  logic                i_done_tick,
    output logic [DATA_BIT-1:0] o_output_pattern,
    output logic [DATA_BIT-1:0] o_freq_pattern,
    output logic                o_start,
    output logic                o_stop,
    output logic                o_mode,
    output logic                o_busy,
    output logic                o_cmd_err
);
    localparam int NBYTES = DATA_BIT / 8;
    localparam int BCW    = (NBYTES > 1) ? $clog2(NBYTES) : 1;

    state_t                r_state, w_state_nxt;
    logic [7:0]            r_op, w_exec_op;
    logic [BCW-1:0]        r_byte_cnt;
    logic [DATA_BIT-1:0]   r_asm, w_asm_nxt, w_full;
    logic [DATA_BIT-1:0]   r_out_shadow, r_freq_shadow, r_out_pat, r_freq_pat;
    logic                  r_out_pend, r_freq_pend;
    logic                  r_buf_vld;
    logic [7:0]            r_buf_data;
    logic                  r_start, r_stop, r_mode, r_busy, r_err;
`ifdef CMD_CHECKSUM_EN
    logic [7:0]            r_csum;
`endif

    logic w_in_vld, w_last_byte, w_tmo, w_wait_byte;
    logic w_go_exec, w_bad_op, w_abort, w_pay_ld, w_op_ld;
    logic w_do_wr_data, w_do_wr_freq, w_do_start, w_do_stop, w_start_ok;
    logic [7:0] w_in_byte;

    // A byte caught during S_EXEC is replayed from the buffer ahead of any live strobe.
    assign w_in_vld    = (r_state != S_EXEC) && (r_buf_vld || i_rx_done_tick);
    assign w_in_byte   = r_buf_vld ? r_buf_data : i_rx_data;
    assign w_last_byte = (r_byte_cnt == BCW'(NBYTES - 1));
    assign w_wait_byte = (r_state == S_PAYLOAD) || (r_state == S_CHECK);

    cmd_timeout_cnt #(.TERM(TIMEOUT_CYCLES)) u_tmo (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_clr  (w_in_vld || !w_wait_byte),
        .i_en   (w_wait_byte),
        .o_tick (w_tmo)
    );

    always_comb begin
        w_asm_nxt = r_asm;
        for (int b = 0; b < NBYTES; b++)
            if (r_byte_cnt == BCW'(b))
                w_asm_nxt[b*8 +: 8] = w_in_byte;
    end

`ifdef CMD_CHECKSUM_EN
    assign w_full = r_asm;
`else
    assign w_full = w_asm_nxt;
`endif

    always_comb begin
        w_state_nxt = r_state;
        w_exec_op   = r_op;
        w_go_exec   = 1'b0;
        w_bad_op    = 1'b0;
        w_abort     = 1'b0;
        w_pay_ld    = 1'b0;
        w_op_ld     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_in_vld) begin
                    w_op_ld   = 1'b1;
                    w_exec_op = w_in_byte;
                    if (op_has_payload(w_in_byte)) begin
                        w_state_nxt = S_PAYLOAD;
                    end else if (op_is_ctrl(w_in_byte)) begin
`ifdef CMD_CHECKSUM_EN
                        w_state_nxt = S_CHECK;
`else
                        w_state_nxt = S_EXEC;
                        w_go_exec   = 1'b1;
`endif
                    end else begin
                        w_bad_op = 1'b1;
                    end
                end
            end
            S_PAYLOAD: begin
                if (w_in_vld) begin
                    w_pay_ld = 1'b1;
                    if (w_last_byte) begin
`ifdef CMD_CHECKSUM_EN
                        w_state_nxt = S_CHECK;
`else
                        w_state_nxt = S_EXEC;
                        w_go_exec   = 1'b1;
`endif
                    end
                end else if (w_tmo) begin
                    w_abort     = 1'b1;
                    w_state_nxt = S_IDLE;
                end
            end
`ifdef CMD_CHECKSUM_EN
            S_CHECK: begin
                if (w_in_vld) begin
                    if (w_in_byte == r_csum) begin
                        w_state_nxt = S_EXEC;
                        w_go_exec   = 1'b1;
                    end else begin
                        w_abort     = 1'b1;
                        w_state_nxt = S_IDLE;
                    end
                end else if (w_tmo) begin
                    w_abort     = 1'b1;
                    w_state_nxt = S_IDLE;
                end
            end
`endif
            S_EXEC:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    assign w_do_wr_data = w_go_exec && (w_exec_op == OP_WR_DATA);
    assign w_do_wr_freq = w_go_exec && (w_exec_op == OP_WR_FREQ);
    assign w_do_start   = w_go_exec && ((w_exec_op == OP_START_1) || (w_exec_op == OP_START_R));
    assign w_do_stop    = w_go_exec && (w_exec_op == OP_STOP);
    // A one-shot completing on this very edge frees serial_out for the new start.
    assign w_start_ok   = !r_busy || (i_done_tick && (r_mode == MODE_ONE_SHOT));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= S_IDLE;
            r_op          <= '0;
            r_byte_cnt    <= '0;
            r_asm         <= '0;
            r_out_shadow  <= '0;
            r_freq_shadow <= '0;
            r_out_pat     <= '0;
            r_freq_pat    <= '0;
            r_out_pend    <= 1'b0;
            r_freq_pend   <= 1'b0;
            r_buf_vld     <= 1'b0;
            r_buf_data    <= '0;
            r_start       <= 1'b0;
            r_stop        <= 1'b0;
            r_mode        <= MODE_ONE_SHOT;
            r_busy        <= 1'b0;
            r_err         <= 1'b0;
`ifdef CMD_CHECKSUM_EN
            r_csum        <= '0;
`endif
        end else begin
            r_state <= w_state_nxt;
            r_start <= 1'b0;
            r_stop  <= 1'b0;
            r_err   <= w_bad_op || w_abort;

            if (i_rx_done_tick && ((r_state == S_EXEC) || r_buf_vld)) begin
                r_buf_vld  <= 1'b1;
                r_buf_data <= i_rx_data;
            end else if (r_buf_vld && (r_state != S_EXEC)) begin
                r_buf_vld  <= 1'b0;
            end

            if (w_op_ld) begin
                r_op       <= w_in_byte;
                r_byte_cnt <= '0;
                r_asm      <= '0;
`ifdef CMD_CHECKSUM_EN
                r_csum     <= w_in_byte;
`endif
            end
            if (w_pay_ld) begin
                r_asm      <= w_asm_nxt;
                r_byte_cnt <= r_byte_cnt + BCW'(1);
`ifdef CMD_CHECKSUM_EN
                r_csum     <= r_csum ^ w_in_byte;
`endif
            end

            if (w_do_wr_data) begin
                r_out_shadow <= w_full;
                if (!r_busy) begin
                    r_out_pat  <= w_full;
                    r_out_pend <= 1'b0;
                end else begin
                    r_out_pend <= 1'b1;
                end
            end else if (w_do_stop) begin
                r_out_pend <= 1'b0;
            end else if (r_out_pend && (i_done_tick || !r_busy)) begin
                r_out_pat  <= r_out_shadow;
                r_out_pend <= 1'b0;
            end

            if (w_do_wr_freq) begin
                r_freq_shadow <= w_full;
                if (!r_busy) begin
                    r_freq_pat  <= w_full;
                    r_freq_pend <= 1'b0;
                end else begin
                    r_freq_pend <= 1'b1;
                end
            end else if (w_do_stop) begin
                r_freq_pend <= 1'b0;
            end else if (r_freq_pend && (i_done_tick || !r_busy)) begin
                r_freq_pat  <= r_freq_shadow;
                r_freq_pend <= 1'b0;
            end

            if (w_do_start) begin
                if (w_start_ok) begin
                    r_start <= 1'b1;
                    r_mode  <= (w_exec_op == OP_START_R) ? MODE_REPEAT : MODE_ONE_SHOT;
                end else begin
                    r_err   <= 1'b1;
                end
            end
            if (w_do_stop)
                r_stop <= 1'b1;

            // Done is applied before a start emitted in the same cycle, so start wins.
            if (r_start)
                r_busy <= 1'b1;
            else if (r_stop)
                r_busy <= 1'b0;
            else if (i_done_tick && (r_mode == MODE_ONE_SHOT))
                r_busy <= 1'b0;
        end
    end

    assign o_output_pattern = r_out_pat;
    assign o_freq_pattern   = r_freq_pat;
    assign o_start          = r_start;
    assign o_stop           = r_stop;
    assign o_mode           = r_mode;
    assign o_busy           = r_busy;
    assign o_cmd_err        = r_err;

endmodule
